half_adder: RTL and testbench
=============================

# half_adder

Registered, lane-parallel half adder. Each of WIDTH independent bit lanes produces sum = a XOR b and carry = a AND b, captured into output registers one clock after a valid input. It is a leaf arithmetic primitive that feeds full-adder and counter datapaths, and it serves as the reference block for adder bring-up benches.

## Interface
- WIDTH, default 1: number of independent 1-bit half-adder lanes; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- in_valid  input  1  qualifies a and b for the current cycle.
- sum  output  WIDTH  registered a[i] XOR b[i].
- carry  output  WIDTH  registered a[i] AND b[i].
- out_valid  output  1  registered copy of in_valid; marks sum and carry as fresh.
- carry_cnt  output  16  saturating count of carry-producing transactions. Present only when HALF_ADDER_CARRY_CNT_EN is defined.

## Operation
- Lanes are fully independent; no carry propagates between lanes.
- On each rising clk edge with rst_n=1 and in_valid=1:
  - sum is loaded with a XOR b.
  - carry is loaded with a AND b.
  - out_valid is set to 1.
- On each rising clk edge with rst_n=1 and in_valid=0:
  - sum and carry hold their previous values.
  - out_valid is set to 0.
- Truth table per lane, as (a,b) -> (sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- X or Z on a or b while in_valid=0 must not affect any register.
- No backpressure. Every valid input is accepted, and the block is always ready.

## Timing
- Latency is 1 cycle from the in_valid sample to out_valid, sum and carry.
- Throughput is one transaction per cycle. Back-to-back valids produce back-to-back results.
- Reset is synchronous. While rst_n=0 at a rising edge, the following outputs go to 0 on that edge and stay 0 while reset is held:
  - sum
  - carry
  - out_valid
  - carry_cnt
- Reset dominates in_valid on the same edge.
- A transaction presented on the edge where rst_n=0 is discarded.
- The first cycle after reset release accepts input normally.
- Reset asserted mid-stream discards any in-flight result; out_valid falls to 0 on that edge.
- There is no combinational path from inputs to outputs.

## Configuration
- HALF_ADDER_CARRY_CNT_EN defined:
  - carry_cnt port and register exist.
  - The counter increments by 1 on each accepted transaction (in_valid=1, rst_n=1) where any lane carry is 1.
  - The counter saturates at 16'hFFFF and does not wrap.
  - The counter updates on the same edge as carry, so it reflects the transaction now shown on the outputs.
- HALF_ADDER_CARRY_CNT_EN undefined:
  - No carry_cnt port and no counter logic.
  - All other behaviour is identical.

## Structure
- Shared package half_adder_pkg holds:
  - CNT_W = 16, the carry counter width.
  - CNT_MAX = 16'hFFFF, the saturation value.
  - WIDTH_MAX = 64, the upper legal bound, checked by an elaboration-time assertion.
- Sub-module half_adder_cell is purely combinational: 1-bit a, b in; sum, carry out. It is instantiated WIDTH times in a generate loop.
- The top level owns all registers and the optional counter.

## Test plan
- WIDTH=1, reset held for 2 cycles, then release: sum=0, carry=0, out_valid=0 (and carry_cnt=0 when enabled) during reset and on the first edge after.
- WIDTH=1, in_valid=1, apply (a,b) = 00, 01, 10, 11 on consecutive cycles:
  - One cycle later, (sum,carry) = 00, 10, 10, 01 respectively.
  - out_valid=1 on each of those cycles.
- WIDTH=1, apply (1,1) with in_valid=1, then (0,1) with in_valid=0: sum=0 and carry=1 are held, out_valid=0.
- WIDTH=8, a=8'hF0, b=8'hCC, in_valid=1: next cycle sum=8'h3C, carry=8'hC0.
- Assert rst_n=0 on the same edge as in_valid=1 with a=b=1: outputs remain 0 and out_valid=0.
- With HALF_ADDER_CARRY_CNT_EN, WIDTH=1:
  - 3 transactions of (1,1) followed by 1 transaction of (1,0) leave carry_cnt=3.
  - Preloading near the limit with 16'hFFFF+2 carry transactions holds carry_cnt at 16'hFFFF.

Source files
------------

// File: rtl/half_adder_pkg.sv
// rtl/half_adder_pkg.sv - shared constants and helpers for the registered half adder
package half_adder_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
  localparam int WIDTH_MAX = 64;

  // Counter increment that sticks at CNT_MAX instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// rtl/half_adder_cell.sv - combinational 1-bit half adder lane
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - registered lane-parallel half adder, 1-cycle latency
// Optional saturating carry counter enabled by HALF_ADDER_CARRY_CNT_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("half_adder: WIDTH out of legal range 1..64");
  end

  logic [WIDTH-1:0] lane_sum;
  logic [WIDTH-1:0] lane_carry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (lane_sum[i]),
      .carry (lane_carry[i])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             valid_q, valid_d;

  // The mux on in_valid keeps undriven inputs from reaching the registers
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = lane_sum;
      carry_d = lane_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|lane_carry)) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - scoreboard bench for half_adder (WIDTH=8)
module tb_half_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         out_valid;
  logic [15:0]  carry_cnt_obs;

  always #5 clk = ~clk;

`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [15:0] carry_cnt;
  assign carry_cnt_obs = carry_cnt;
`else
  assign carry_cnt_obs = 16'h0;
`endif

  half_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
`ifdef HALF_ADDER_CARRY_CNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  typedef struct {
    logic         v;
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [15:0]  n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs should show after the coming edge
  logic         m_v = 1'b0;
  logic [W-1:0] m_s = '0;
  logic [W-1:0] m_c = '0;
  int           m_n = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    if (!r) begin
      m_v = 1'b0; m_s = '0; m_c = '0; m_n = 0;
    end else if (v) begin
      m_v = 1'b1;
      for (int i = 0; i < W; i++) begin
        m_s[i] = ((aa[i] + bb[i]) % 2) != 0;
        m_c[i] = (aa[i] + bb[i]) == 2;
      end
`ifdef HALF_ADDER_CARRY_CNT_EN
      if (m_c != 0 && m_n < 65535) m_n = m_n + 1;
`endif
    end else begin
      m_v = 1'b0;
    end
    q.push_back('{m_v, m_s, m_c, m_n[15:0]});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid", {63'b0, out_valid}, {63'b0, e.v});
        chk("sum", {56'b0, sum}, {56'b0, e.s});
        chk("carry", {56'b0, carry}, {56'b0, e.c});
`ifdef HALF_ADDER_CARRY_CNT_EN
        chk("carry_cnt", {48'b0, carry_cnt_obs}, {48'b0, e.n});
`endif
      end
    end
  end

  initial begin : stim
    logic [W-1:0] xv;
    xv = 'x;
    // Reset held two cycles, then an idle cycle after release
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    // Truth table on all lanes, back to back
    step(1'b1, 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b1, 8'h00, 8'hFF);
    step(1'b1, 1'b1, 8'hFF, 8'h00);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    // Hold with in_valid low, including unknown operands
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, 8'h00, 8'hFF);
    step(1'b1, 1'b0, xv, xv);
    // Mixed lanes
    step(1'b1, 1'b1, 8'hF0, 8'hCC);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    // Reset dominates a valid transaction
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    // Carry counting: three carries then a non-carry
    step(1'b1, 1'b1, 8'h01, 8'h01);
    step(1'b1, 1'b1, 8'h01, 8'h01);
    step(1'b1, 1'b1, 8'h01, 8'h01);
    step(1'b1, 1'b1, 8'h01, 8'h00);
    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 24) != 0, $urandom_range(0, 1) == 1,
           W'($urandom), W'($urandom));
    end
`ifdef HALF_ADDER_CARRY_CNT_EN
    step(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 65537; i++) begin
      step(1'b1, 1'b1, 8'h80, 8'h80);
    end
    step(1'b1, 1'b0, '0, '0);
`endif
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never appeared, expected 0 pending", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
